// File: rtl/aes_v3_pkg.sv
// Shared types and helpers for the saes.v3 round sequencer (FSM encoding, index types, word/ShiftRows select).
package aes_v3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_t;

  typedef logic [1:0] word_idx_t;
  typedef logic [1:0] byte_idx_t;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  function automatic logic [31:0] word_sel(input logic [127:0] bus, input word_idx_t w);
    logic [31:0] r;
    case (w)
      2'd0:    r = bus[31:0];
      2'd1:    r = bus[63:32];
      2'd2:    r = bus[95:64];
      2'd3:    r = bus[127:96];
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Row i of output column j comes from column j+i (ShiftRows) or j-i (InvShiftRows), mod 4.
  function automatic word_idx_t src_word(input word_idx_t j, input byte_idx_t i, input logic dec);
    word_idx_t r;
    if (dec) begin
      r = j - i;
    end else begin
      r = j + i;
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_v3_seq_addr.sv
// Operand select for one saes.v3 byte-op: source state word, byte select, and key/accumulator chain.
module aes_v3_seq_addr
  import aes_v3_pkg::*;
(
  input  logic [1:0]   j,
  input  logic [1:0]   i,
  input  logic         dec,
  input  logic [31:0]  acc,
  input  logic [127:0] rkey,
  input  logic [127:0] state,
  output logic [31:0]  rs1,
  output logic [31:0]  rs2,
  output logic [1:0]   bs
);

  assign rs1 = word_sel(state, src_word(j, i, dec));
  // The first byte of each column starts from the round key; the rest chain through the accumulator.
  assign rs2 = (i == 2'd0) ? word_sel(rkey, j) : acc;
  assign bs  = i;

endmodule

// File: rtl/aes_v3_round_seq.sv
// Sequences the 16 saes.v3 byte-ops of one AES round onto a shared single-byte core.
// Optional build macro AES_V3_SEQ_PERF_EN adds the stall_cnt output.
module aes_v3_round_seq
  import aes_v3_pkg::*;
(
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         start,
  input  logic         dec,
  input  logic         last,
  input  logic [127:0] state_in,
  input  logic [127:0] rkey,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out,
  output logic         c_valid,
  output logic         c_dec,
  output logic         c_mix,
  output logic [31:0]  c_rs1,
  output logic [31:0]  c_rs2,
  output logic [1:0]   c_bs,
  input  logic         c_ready,
  input  logic [31:0]  c_rd
`ifdef AES_V3_SEQ_PERF_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);

  seq_state_t   fsm_r;
  logic [1:0]   j_r;
  logic [1:0]   i_r;
  logic         dec_r;
  logic         last_r;
  logic [127:0] state_r;
  logic [127:0] rkey_r;
  logic [31:0]  acc_r;
  logic [127:0] result_r;
  logic [127:0] state_out_r;
  logic         done_r;
  logic         issue_s;

  assign issue_s   = (fsm_r == ST_ISSUE);
  assign busy      = issue_s;
  assign c_valid   = issue_s;
  assign c_dec     = dec_r;
  assign c_mix     = ~last_r;
  assign done      = done_r;
  assign state_out = state_out_r;

  aes_v3_seq_addr u_addr (
    .j     (j_r),
    .i     (i_r),
    .dec   (dec_r),
    .acc   (acc_r),
    .rkey  (rkey_r),
    .state (state_r),
    .rs1   (c_rs1),
    .rs2   (c_rs2),
    .bs    (c_bs)
  );

  // Round FSM: capture on start, walk (j,i) over 16 accepted ops, publish the result on the last one.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      fsm_r       <= ST_IDLE;
      j_r         <= 2'd0;
      i_r         <= 2'd0;
      dec_r       <= 1'b0;
      last_r      <= 1'b0;
      state_r     <= 128'd0;
      rkey_r      <= 128'd0;
      acc_r       <= 32'd0;
      result_r    <= 128'd0;
      state_out_r <= 128'd0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (fsm_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= state_in;
            rkey_r  <= rkey;
            dec_r   <= dec;
            last_r  <= last;
            j_r     <= 2'd0;
            i_r     <= 2'd0;
            fsm_r   <= ST_ISSUE;
          end else begin
            fsm_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (c_ready) begin
            acc_r <= c_rd;
            if (i_r == 2'd3) begin
              result_r[{j_r, 5'd0} +: 32] <= c_rd;
              i_r <= 2'd0;
              j_r <= j_r + 2'd1;
              if (j_r == 2'd3) begin
                // Column 3 arrives on this edge, so splice it in directly.
                state_out_r <= {c_rd, result_r[95:0]};
                done_r      <= 1'b1;
                fsm_r       <= ST_DONE;
              end else begin
                fsm_r <= ST_ISSUE;
              end
            end else begin
              i_r <= i_r + 2'd1;
            end
          end else begin
            fsm_r <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          fsm_r <= ST_IDLE;
        end
        default: begin
          fsm_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef AES_V3_SEQ_PERF_EN
  logic [15:0] stall_cnt_r;

  assign stall_cnt = stall_cnt_r;

  // Core back-pressure counter, saturating, cleared on an accepted start.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      stall_cnt_r <= 16'd0;
    end else if ((fsm_r == ST_IDLE) && start) begin
      stall_cnt_r <= 16'd0;
    end else if (c_valid && !c_ready && (stall_cnt_r != STALL_MAX)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_aes_v3_round_seq.sv
// Self-checking bench for aes_v3_round_seq with a behavioural saes.v3 byte core and a whole-round AES model.
`timescale 1ns/1ps
module tb_aes_v3_round_seq;

  logic         g_clk;
  logic         g_resetn;
  logic         start;
  logic         dec;
  logic         last;
  logic [127:0] state_in;
  logic [127:0] rkey;
  logic         busy;
  logic         done;
  logic [127:0] state_out;
  logic         c_valid;
  logic         c_dec;
  logic         c_mix;
  logic [31:0]  c_rs1;
  logic [31:0]  c_rs2;
  logic [1:0]   c_bs;
  logic         c_ready;
  logic [31:0]  c_rd;
`ifdef AES_V3_SEQ_PERF_EN
  logic [15:0]  stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] sbox_t [256];
  logic [7:0] inv_t  [256];

  int           r_cycles, r_dones, r_stalls, r_unstable, r_mix_ops, r_ops;
  bit           r_timeout, r_held;
  logic         r_busy_after;
  logic [127:0] r_out;
  logic [15:0]  r_stall_cnt;

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  aes_v3_round_seq dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .start     (start),
    .dec       (dec),
    .last      (last),
    .state_in  (state_in),
    .rkey      (rkey),
    .busy      (busy),
    .done      (done),
    .state_out (state_out),
    .c_valid   (c_valid),
    .c_dec     (c_dec),
    .c_mix     (c_mix),
    .c_rs1     (c_rs1),
    .c_rs2     (c_rs2),
    .c_bs      (c_bs),
    .c_ready   (c_ready),
    .c_rd      (c_rd)
`ifdef AES_V3_SEQ_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // FIPS-197 text lists byte 0 first; the bus carries byte 0 in the low bits.
  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] y;
    for (int k = 0; k < 16; k++) y[8*k +: 8] = x[8*(15-k) +: 8];
    return y;
  endfunction

  task automatic init_tables;
    logic [7:0] a, y, s;
    for (int x = 0; x < 256; x++) begin
      a = 8'(x);
      y = 8'h01;
      for (int n = 0; n < 254; n++) y = gmul(y, a);
      s = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
      sbox_t[x] = s;
      inv_t[s]  = 8'(x);
    end
  endtask

  // Textbook round on a 4x4 byte matrix: (Inv)SubBytes, (Inv)ShiftRows, optional (Inv)MixColumns, AddRoundKey.
  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic d, input logic l);
    logic [7:0]   b [16];
    logic [7:0]   sh [16];
    logic [7:0]   coef [4];
    logic [7:0]   v;
    logic [127:0] r;
    for (int k = 0; k < 16; k++) b[k] = d ? inv_t[st[8*k +: 8]] : sbox_t[st[8*k +: 8]];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        sh[4*c+rw] = d ? b[4*((c - rw + 4) % 4) + rw] : b[4*((c + rw) % 4) + rw];
    if (d) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else   coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        if (l) v = sh[4*c+rw];
        else begin
          v = 8'h00;
          for (int k = 0; k < 4; k++) v = v ^ gmul(coef[(k - rw + 4) % 4], sh[4*c+k]);
        end
        r[8*(4*c+rw) +: 8] = v ^ rk[8*(4*c+rw) +: 8];
      end
    end
    return r;
  endfunction

  // Behavioural saes.v3 byte core: rd = rs2 ^ rotl(column(sbox(rs1.byte[bs])), 8*bs).
  logic [7:0]  core_x, core_s;
  logic [31:0] core_col;
  always_comb begin
    core_x = c_rs1[8*c_bs +: 8];
    core_s = c_dec ? inv_t[core_x] : sbox_t[core_x];
    if (!c_mix) core_col = {24'h0, core_s};
    else if (c_dec) core_col = {gmul(core_s, 8'h0b), gmul(core_s, 8'h0d), gmul(core_s, 8'h09), gmul(core_s, 8'h0e)};
    else core_col = {gmul(core_s, 8'h03), core_s, core_s, gmul(core_s, 8'h02)};
    c_rd = c_rs2 ^ ((core_col << (8*c_bs)) | (core_col >> (32 - 8*c_bs)));
  end

  function automatic int pick_wait(input int max_wait);
    return (max_wait == 0) ? 0 : int'($urandom_range(max_wait, 0));
  endfunction

  // Drive one round and record what happened; ign_at>0 pulses a competing start mid-round.
  task automatic run_round(input logic [127:0] st, input logic [127:0] rk, input logic d, input logic l,
                           input int max_wait, input int ign_at, input bit start_in_done);
    int         wait_left;
    logic [68:0] snap;
    bit         prev_stall;
    r_cycles = 0; r_dones = 0; r_stalls = 0; r_unstable = 0; r_mix_ops = 0; r_ops = 0;
    r_timeout = 1'b1; r_held = 1'b1; r_busy_after = 1'bx; r_out = 128'd0;
    prev_stall = 1'b0;
    snap = '0;
    wait_left = pick_wait(max_wait);
    @(negedge g_clk);
    state_in = st; rkey = rk; dec = d; last = l; start = 1'b1; c_ready = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge g_clk);
      start = 1'b0;
      if (cyc == 1) begin
        state_in = {$urandom, $urandom, $urandom, $urandom};
        rkey     = {$urandom, $urandom, $urandom, $urandom};
        dec      = ~d;
        last     = ~l;
      end
      if (cyc == ign_at) begin
        start    = 1'b1;
        state_in = ~st;
      end
      if (prev_stall && (snap !== {c_valid, c_dec, c_mix, c_bs, c_rs1, c_rs2})) r_unstable++;
      if (done === 1'b1) begin
        r_dones++;
        if (r_dones == 1) begin
          r_cycles  = cyc;
          r_out     = state_out;
          r_timeout = 1'b0;
          if (start_in_done) start = 1'b1;
        end
      end
      if (r_dones > 0 && cyc == r_cycles + 1) r_busy_after = busy;
      if (r_dones > 0 && cyc == r_cycles + 3) begin
        if (state_out !== r_out) r_held = 1'b0;
        break;
      end
      prev_stall = 1'b0;
      snap = {c_valid, c_dec, c_mix, c_bs, c_rs1, c_rs2};
      if (c_valid === 1'b1) begin
        if (wait_left == 0) begin
          c_ready = 1'b1;
          r_ops++;
          if (c_mix === 1'b1) r_mix_ops++;
          wait_left = pick_wait(max_wait);
        end else begin
          c_ready = 1'b0;
          wait_left--;
          r_stalls++;
          prev_stall = 1'b1;
        end
      end else begin
        c_ready = 1'b0;
      end
    end
    c_ready = 1'b0;
    start   = 1'b0;
`ifdef AES_V3_SEQ_PERF_EN
    r_stall_cnt = stall_cnt;
`else
    r_stall_cnt = 16'(r_stalls);
`endif
  endtask

  task automatic test_reset;
    repeat (2) @(negedge g_clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL reset_c_valid: got %b want 0", c_valid); end
    checks++; if (state_out !== 128'd0) begin errors++; $display("FAIL reset_state_out: got %h want 0", state_out); end
    g_resetn = 1'b1;
  endtask

  task automatic test_enc_middle;
    logic [127:0] st, rk, exp;
    st  = bswap(128'h00102030405060708090a0b0c0d0e0f0);
    rk  = bswap(128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    exp = bswap(128'h89d810e8855ace682d1843d8cb128fe4);
    run_round(st, rk, 1'b0, 1'b0, 0, 0, 1'b0);
    checks++; if (r_out !== exp) begin errors++; $display("FAIL enc_mid_out: got %h want %h", r_out, exp); end
    checks++; if (r_cycles !== 17) begin errors++; $display("FAIL enc_mid_latency: got %0d want 17", r_cycles); end
    checks++; if (r_dones !== 1) begin errors++; $display("FAIL enc_mid_done_count: got %0d want 1", r_dones); end
    checks++; if (r_mix_ops !== 16) begin errors++; $display("FAIL enc_mid_mix_ops: got %0d want 16", r_mix_ops); end
    checks++; if (r_held !== 1'b1) begin errors++; $display("FAIL enc_mid_hold: state_out changed after done"); end
  endtask

  task automatic test_enc_final;
    logic [127:0] st, rk, exp;
    st  = bswap(128'hbd6e7c3df2b5779e0b61216e8b10b689);
    rk  = bswap(128'h13111d7fe3944a17f307a78b4d2b30c5);
    exp = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    run_round(st, rk, 1'b0, 1'b1, 0, 0, 1'b0);
    checks++; if (r_out !== exp) begin errors++; $display("FAIL enc_final_out: got %h want %h", r_out, exp); end
    checks++; if (r_mix_ops !== 0) begin errors++; $display("FAIL enc_final_mix_ops: got %0d want 0", r_mix_ops); end
    checks++; if (r_ops !== 16) begin errors++; $display("FAIL enc_final_ops: got %0d want 16", r_ops); end
  endtask

  task automatic test_dec_final;
    logic [127:0] st, rk, exp;
    st  = bswap(128'h6353e08c0960e104cd70b751bacad0e7);
    rk  = bswap(128'h000102030405060708090a0b0c0d0e0f);
    exp = bswap(128'h00112233445566778899aabbccddeeff);
    run_round(st, rk, 1'b1, 1'b1, 0, 0, 1'b0);
    checks++; if (r_out !== exp) begin errors++; $display("FAIL dec_final_out: got %h want %h", r_out, exp); end
    checks++; if (r_cycles !== 17) begin errors++; $display("FAIL dec_final_latency: got %0d want 17", r_cycles); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] sts [3];
    logic [127:0] rks [3];
    logic [127:0] exs [3];
    logic [1:0]   mode [3];
    logic [127:0] st, rk, exp;
    logic         d, l;
    sts[0] = bswap(128'h00102030405060708090a0b0c0d0e0f0); rks[0] = bswap(128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    exs[0] = bswap(128'h89d810e8855ace682d1843d8cb128fe4); mode[0] = 2'b00;
    sts[1] = bswap(128'hbd6e7c3df2b5779e0b61216e8b10b689); rks[1] = bswap(128'h13111d7fe3944a17f307a78b4d2b30c5);
    exs[1] = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a); mode[1] = 2'b01;
    sts[2] = bswap(128'h6353e08c0960e104cd70b751bacad0e7); rks[2] = bswap(128'h000102030405060708090a0b0c0d0e0f);
    exs[2] = bswap(128'h00112233445566778899aabbccddeeff); mode[2] = 2'b11;
    for (int n = 0; n < 11; n++) begin
      if (n < 3) begin
        st = sts[n]; rk = rks[n]; exp = exs[n]; d = mode[n][1]; l = mode[n][0];
      end else begin
        st = {$urandom, $urandom, $urandom, $urandom};
        rk = {$urandom, $urandom, $urandom, $urandom};
        d  = 1'($urandom_range(1, 0));
        l  = 1'($urandom_range(1, 0));
        exp = aes_round(st, rk, d, l);
      end
      run_round(st, rk, d, l, 5, 0, 1'b0);
      checks++; if (r_out !== exp) begin errors++; $display("FAIL bp_out[%0d]: got %h want %h (dec=%b last=%b)", n, r_out, exp, d, l); end
      checks++; if (r_cycles !== 17 + r_stalls) begin errors++; $display("FAIL bp_latency[%0d]: got %0d want %0d", n, r_cycles, 17 + r_stalls); end
      checks++; if (r_unstable !== 0) begin errors++; $display("FAIL bp_stable[%0d]: got %0d changes want 0", n, r_unstable); end
      checks++; if (r_mix_ops !== (l ? 0 : 16)) begin errors++; $display("FAIL bp_mix[%0d]: got %0d want %0d", n, r_mix_ops, l ? 0 : 16); end
`ifdef AES_V3_SEQ_PERF_EN
      checks++; if (r_stall_cnt !== 16'(r_stalls)) begin errors++; $display("FAIL bp_stall_cnt[%0d]: got %0d want %0d", n, r_stall_cnt, r_stalls); end
`endif
    end
  endtask

  task automatic test_start_ignored;
    logic [127:0] st, rk, exp;
    st  = {$urandom, $urandom, $urandom, $urandom};
    rk  = {$urandom, $urandom, $urandom, $urandom};
    exp = aes_round(st, rk, 1'b1, 1'b0);
    run_round(st, rk, 1'b1, 1'b0, 0, 5, 1'b1);
    checks++; if (r_out !== exp) begin errors++; $display("FAIL ign_out: got %h want %h", r_out, exp); end
    checks++; if (r_dones !== 1) begin errors++; $display("FAIL ign_done_count: got %0d want 1", r_dones); end
    checks++; if (r_busy_after !== 1'b0) begin errors++; $display("FAIL ign_start_in_done: busy got %b want 0", r_busy_after); end
    checks++; if (r_cycles !== 17) begin errors++; $display("FAIL ign_latency: got %0d want 17", r_cycles); end
  endtask

  task automatic test_reset_mid;
    logic [127:0] st, rk, exp;
    int           n_done, n_busy;
    st = {$urandom, $urandom, $urandom, $urandom};
    rk = {$urandom, $urandom, $urandom, $urandom};
    @(negedge g_clk);
    state_in = st; rkey = rk; dec = 1'b0; last = 1'b0; start = 1'b1; c_ready = 1'b1;
    @(negedge g_clk);
    start = 1'b0;
    repeat (6) @(negedge g_clk);
    checks++; if (c_valid !== 1'b1 || c_bs !== 2'd2) begin errors++; $display("FAIL rstmid_op7: valid=%b bs=%0d want 1/2", c_valid, c_bs); end
    g_resetn = 1'b0;
    @(negedge g_clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL rstmid_c_valid: got %b want 0", c_valid); end
    checks++; if (state_out !== 128'd0) begin errors++; $display("FAIL rstmid_state_out: got %h want 0", state_out); end
    g_resetn = 1'b1;
    c_ready  = 1'b0;
    n_done = 0;
    n_busy = 0;
    repeat (20) begin
      @(negedge g_clk);
      if (done !== 1'b0) n_done++;
      if (busy !== 1'b0) n_busy++;
    end
    checks++; if (n_done !== 0 || n_busy !== 0) begin errors++; $display("FAIL rstmid_abandon: done=%0d busy=%0d cycles want 0/0", n_done, n_busy); end
    exp = aes_round(rk, st, 1'b1, 1'b0);
    run_round(rk, st, 1'b1, 1'b0, 2, 0, 1'b0);
    checks++; if (r_out !== exp) begin errors++; $display("FAIL rstmid_next_round: got %h want %h", r_out, exp); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    g_resetn = 1'b0;
    start    = 1'b0;
    dec      = 1'b0;
    last     = 1'b0;
    state_in = 128'd0;
    rkey     = 128'd0;
    c_ready  = 1'b0;
    init_tables();
    test_reset();
    test_enc_middle();
    test_enc_final();
    test_dec_final();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
